// File: rtl/mmio_master.sv
// mmio_master
// Single-outstanding bus initiator between the core data port and the shared
// peripheral bus. A load or store is latched from the core and driven onto the
// bus as a read or write strobe. The initiator then waits for the OR-combined
// responder acknowledge and returns exactly one response pulse to the core.
// If no acknowledge arrives within TIMEOUT cycles, the request completes with
// rsp_err set.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   req_*           core request (valid/ready handshake; ready only in IDLE)
//   rsp_*           one-cycle response pulse with read data and error flag
//   bus_rd/bus_wr   strobes to responders (decoded from state)
//   bus_addr/...    address, byte mask and write data (zero when idle)
//   bus_rd_valid    combinational read acknowledge from responders
//   bus_wr_valid    registered write acknowledge from responders
//   bus_rdata       OR of responder read data

module mmio_master #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [3:0]  req_wrmask,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        bus_rd,
   output logic        bus_wr,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_wrmask,
   output logic [31:0] bus_wdata,
   input  logic        bus_rd_valid,
   input  logic        bus_wr_valid,
   input  logic [31:0] bus_rdata
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      RD,
      WR_ISSUE,
      WR_WAIT,
      RESP
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   addr_q, addr_d;
   logic [3:0]    wrmask_q, wrmask_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;
   logic          rsp_valid_q, rsp_valid_d;

   // State and datapath registers. The latched request doubles as the bus
   // address/mask/data outputs, so these registers are cleared whenever the
   // bus goes idle. That way responders never see a stale address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         wrmask_q    <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wrmask_q    <= wrmask_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   // Next-state and datapath updates. Entering RESP raises the registered
   // response pulse and blanks the bus in the same edge.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      wrmask_d    = wrmask_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      rsp_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d   = req_addr;
               wrmask_d = req_wrmask;
               wdata_d  = req_wdata;
               rdata_d  = '0;
               err_d    = 1'b0;
               cnt_d    = '0;
               state_d  = req_we ? WR_ISSUE : RD;
            end
         end
         RD, WR_WAIT: begin
            // An acknowledge of the matching kind wins over a timeout that
            // expires in the same cycle.
            if ((state_q == RD && bus_rd_valid) || (state_q == WR_WAIT && bus_wr_valid)) begin
               if (state_q == RD) begin
                  rdata_d = bus_rdata;
               end
               err_d   = 1'b0;
               state_d = RESP;
            end else if (cnt_q == CNT_LAST) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WR_ISSUE: begin
            state_d = WR_WAIT;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (state_q != RESP && state_d == RESP) begin
         rsp_valid_d = 1'b1;
         addr_d      = '0;
         wrmask_d    = '0;
         wdata_d     = '0;
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign bus_rd     = (state_q == RD);
   assign bus_wr     = (state_q == WR_ISSUE);
   assign bus_addr   = addr_q;
   assign bus_wrmask = wrmask_q;
   assign bus_wdata  = wdata_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_rdata  = rdata_q;
   assign rsp_err    = err_q;

endmodule

// File: tb/tb_mmio_master.sv
// tb_mmio_master
// Self-checking bench for mmio_master. The bench itself plays the role of the
// responders: for each transaction it decides whether the address decodes and
// on which cycle an acknowledge appears. A transaction-level model predicts
// the response cycle, data and error flag from those choices. The model also
// predicts the strobe/address pattern expected on every cycle.

module tb_mmio_master;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [3:0]  req_wrmask;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        bus_rd;
   logic        bus_wr;
   logic [31:0] bus_addr;
   logic [3:0]  bus_wrmask;
   logic [31:0] bus_wdata;
   logic        bus_rd_valid;
   logic        bus_wr_valid;
   logic [31:0] bus_rdata;

   int total = 0;
   int bad   = 0;

   // Free-running 10-time-unit clock.
   always #5 clk = ~clk;

   mmio_master #(.TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_wrmask   (req_wrmask),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .bus_rd       (bus_rd),
      .bus_wr       (bus_wr),
      .bus_addr     (bus_addr),
      .bus_wrmask   (bus_wrmask),
      .bus_wdata    (bus_wdata),
      .bus_rd_valid (bus_rd_valid),
      .bus_wr_valid (bus_wr_valid),
      .bus_rdata    (bus_rdata)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s at %0t: got 0x%08h, want 0x%08h", tag, $time, observed, expected);
      end
   endtask

   // Runs one transaction starting in the current (idle) cycle, which becomes
   // accept cycle T. ackAt is the cycle offset after T on which the responder
   // presents its acknowledge, if it decodes the request at all. spurAt is an
   // offset at which an acknowledge of the wrong kind is injected.
   task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [3:0] mask,
                                input logic [31:0] wdata, input logic respond, input int ackAt,
                                input logic [31:0] rdataIn, input int spurAt, input logic holdValid);
      logic        hit;
      int          rspCycle;
      logic [31:0] expData;
      logic        expErr;

      // Transaction-level expectation: a read completes the cycle after its
      // acknowledge if that arrives within TIMEOUT strobe cycles. A write has
      // one extra issue cycle in front of its waiting window.
      if (!we) begin
         hit      = respond && ackAt >= 1 && ackAt <= TIMEOUT;
         rspCycle = hit ? ackAt + 1 : TIMEOUT + 1;
      end else begin
         hit      = respond && ackAt >= 2 && ackAt <= TIMEOUT + 1;
         rspCycle = hit ? ackAt + 1 : TIMEOUT + 2;
      end
      expData = (!we && hit) ? rdataIn : 32'h0;
      expErr  = !hit;

      req_valid    = 1'b1;
      req_we       = we;
      req_addr     = addr;
      req_wrmask   = mask;
      req_wdata    = wdata;
      bus_rd_valid = 1'($urandom_range(0, 1));
      bus_wr_valid = 1'($urandom_range(0, 1));
      bus_rdata    = $urandom;
      checkOutput("req_ready_accept", req_ready, 1);
      checkOutput("rsp_valid_accept", rsp_valid, 0);
      checkOutput("bus_addr_idle", bus_addr, 0);
      @(posedge clk);
      #1;
      if (!holdValid) req_valid = 1'b0;

      for (int k = 1; k <= rspCycle; k++) begin
         bus_rd_valid = (respond && !we && k == ackAt) || (we && k == spurAt);
         bus_wr_valid = (respond && we && k == ackAt) || (!we && k == spurAt);
         if (respond && !we && k == ackAt)
            bus_rdata = rdataIn;
         else if (we && k == spurAt)
            bus_rdata = $urandom;
         else
            bus_rdata = 32'h0;

         checkOutput("bus_rd", bus_rd, !we && k < rspCycle);
         checkOutput("bus_wr", bus_wr, we && k == 1);
         checkOutput("req_ready_busy", req_ready, 0);
         checkOutput("bus_addr", bus_addr, (k < rspCycle) ? addr : 32'h0);
         checkOutput("bus_wrmask", bus_wrmask, (k < rspCycle) ? mask : 4'h0);
         checkOutput("bus_wdata", bus_wdata, (k < rspCycle) ? wdata : 32'h0);
         checkOutput("rsp_valid", rsp_valid, k == rspCycle);
         if (k == rspCycle) begin
            checkOutput("rsp_rdata", rsp_rdata, expData);
            checkOutput("rsp_err", rsp_err, expErr);
         end
         @(posedge clk);
         #1;
      end
      bus_rd_valid = 1'b0;
      bus_wr_valid = 1'b0;
      bus_rdata    = 32'h0;
   endtask

   initial begin
      logic        we;
      logic        respond;
      int          region;
      int          ackAt;
      logic [31:0] addr;

      rst          = 1'b1;
      req_valid    = 1'b0;
      req_we       = 1'b0;
      req_addr     = 32'h0;
      req_wrmask   = 4'h0;
      req_wdata    = 32'h0;
      bus_rd_valid = 1'b0;
      bus_wr_valid = 1'b0;
      bus_rdata    = 32'h0;

      #2;
      checkOutput("reset_req_ready", req_ready, 1);
      checkOutput("reset_rsp_valid", rsp_valid, 0);
      checkOutput("reset_rsp_rdata", rsp_rdata, 0);
      checkOutput("reset_rsp_err", rsp_err, 0);
      checkOutput("reset_bus_rd", bus_rd, 0);
      checkOutput("reset_bus_wr", bus_wr, 0);
      checkOutput("reset_bus_addr", bus_addr, 0);
      checkOutput("reset_bus_wrmask", bus_wrmask, 0);
      checkOutput("reset_bus_wdata", bus_wdata, 0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Directed transactions from the bring-up list.
      applyStimulus(0, 32'h2000_0000, 4'h0, 32'h0, 1, 1, 32'hA5A5_0001, 0, 0);
      applyStimulus(1, 32'h2000_0004, 4'hF, 32'hDEAD_BEEF, 1, 2, 32'h0, 0, 0);
      applyStimulus(0, 32'h3000_0000, 4'h0, 32'h0, 0, 0, 32'h0, 0, 0);
      applyStimulus(1, 32'h2000_0100, 4'h3, 32'h0BAD_F00D, 0, 2, 32'h0, 0, 0);
      applyStimulus(0, 32'h2000_0008, 4'h0, 32'h0, 1, TIMEOUT, 32'h0000_1234, 0, 0);
      applyStimulus(0, 32'h2000_000C, 4'h0, 32'h0, 1, 3, 32'hCAFE_0003, 2, 0);
      applyStimulus(1, 32'h2000_0000, 4'h5, 32'h1111_2222, 1, TIMEOUT + 1, 32'h0, 1, 0);

      // Three queued reads with req_valid never dropping.
      applyStimulus(0, 32'h2000_0000, 4'h0, 32'h0, 1, 1, 32'h0000_0001, 0, 1);
      applyStimulus(0, 32'h2000_0004, 4'h0, 32'h0, 1, 1, 32'h0000_0002, 0, 1);
      applyStimulus(0, 32'h2000_0008, 4'h0, 32'h0, 1, 1, 32'h0000_0003, 0, 0);

      // Reset while a write is waiting for its acknowledge.
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_addr   = 32'h2000_0004;
      req_wrmask = 4'hF;
      req_wdata  = 32'h5555_AAAA;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("wr_wait_bus_wr", bus_wr, 0);
      checkOutput("wr_wait_bus_addr", bus_addr, 32'h2000_0004);
      rst = 1'b1;
      #1;
      checkOutput("rst_mid_bus_wr", bus_wr, 0);
      checkOutput("rst_mid_bus_rd", bus_rd, 0);
      checkOutput("rst_mid_bus_addr", bus_addr, 0);
      checkOutput("rst_mid_bus_wdata", bus_wdata, 0);
      checkOutput("rst_mid_bus_wrmask", bus_wrmask, 0);
      checkOutput("rst_mid_req_ready", req_ready, 1);
      @(posedge clk);
      #1;
      rst          = 1'b0;
      bus_wr_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         checkOutput("post_rst_rsp_valid", rsp_valid, 0);
         checkOutput("post_rst_req_ready", req_ready, 1);
         @(posedge clk);
         #1;
         bus_wr_valid = 1'b0;
      end

      // Randomized traffic: region 0 is read/write, region 1 is unmapped,
      // and region 2 is read-only (reads ack, writes never do).
      for (int n = 0; n < 60; n++) begin
         region  = $urandom_range(0, 2);
         we      = 1'($urandom_range(0, 1));
         case (region)
            0:       addr = 32'h2000_0000 + 32'($urandom_range(0, 3) * 4);
            1:       addr = 32'h3000_0000 | ($urandom & 32'h0000_FFFC);
            default: addr = 32'h2000_0100;
         endcase
         respond = (region == 0) || (region == 2 && !we);
         if ($urandom_range(0, 1) == 1)
            ackAt = we ? $urandom_range(2, 4) : $urandom_range(1, 3);
         else
            ackAt = we ? $urandom_range(2, TIMEOUT + 3) : $urandom_range(1, TIMEOUT + 2);
         applyStimulus(we, addr, 4'($urandom), $urandom, respond, ackAt, $urandom,
                       $urandom_range(0, TIMEOUT + 2), 1'($urandom_range(0, 1)));
      end

      req_valid = 1'b0;
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mmio_master.md
# mmio_master

Bus initiator for the SoC peripheral bus. It takes single-beat load/store requests from the core's data port and drives them onto the shared peripheral bus as `rd`/`wr` strobes, address, write mask and write data. It waits for the OR-combined responder acknowledge (`rd_valid`/`wr_valid`/`data`), then returns one response per request to the core. Missing acknowledges are converted into a bus-error response after a bounded timeout.

## Interface

Parameters:
- `TIMEOUT`, default 16: maximum cycles spent waiting for an acknowledge; legal range ≥ 2.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  1  core request present
- `req_ready`  out  1  initiator can accept a request (high only in IDLE)
- `req_we`  in  1  1 = write, 0 = read
- `req_addr`  in  32  byte address
- `req_wrmask`  in  4  byte enables for writes
- `req_wdata`  in  32  write data
- `rsp_valid`  out  1  one-cycle response pulse
- `rsp_rdata`  out  32  read data; 0 for writes and errors
- `rsp_err`  out  1  timeout error, qualified by `rsp_valid`
- `bus_rd`  out  1  read strobe to responders
- `bus_wr`  out  1  write strobe to responders
- `bus_addr`  out  32  address to responders
- `bus_wrmask`  out  4  byte enables to responders
- `bus_wdata`  out  32  write data to responders
- `bus_rd_valid`  in  1  OR of responder read acknowledges (combinational in responders)
- `bus_wr_valid`  in  1  OR of responder write acknowledges (registered in responders, one cycle after `wr`)
- `bus_rdata`  in  32  OR of responder read data (non-selected responders drive 0)

## Operation

- States: IDLE, RD, WR_ISSUE, WR_WAIT, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch we/addr/wrmask/wdata and clear the timeout counter.
  - Go to RD if `req_we`=0, otherwise WR_ISSUE.
- RD:
  - `bus_rd`=1.
  - If `bus_rd_valid`=1, capture `bus_rdata`, set err=0 and go to RESP.
  - Otherwise, if counter == TIMEOUT-1, set err=1 and rdata=0 and go to RESP; else increment the counter.
- WR_ISSUE:
  - `bus_wr`=1 for exactly this one cycle, unconditionally.
  - Go to WR_WAIT; the counter stays 0.
- WR_WAIT:
  - `bus_wr`=0; address, mask and data are held.
  - If `bus_wr_valid`=1, set err=0 and go to RESP.
  - Otherwise apply the same timeout rule as RD.
- RESP:
  - `rsp_valid`=1 with the registered rdata/err.
  - Return to IDLE.
- `bus_addr`/`bus_wrmask`/`bus_wdata` carry the latched values in RD, WR_ISSUE and WR_WAIT, and are 0 in IDLE and RESP. This prevents stray decode in responders.
- Acks that do not match the current state are ignored: `bus_wr_valid` in RD, `bus_rd_valid` in WR_ISSUE/WR_WAIT, and any ack in IDLE/RESP.
- If an ack arrives in the same cycle the timeout expires, the ack wins: err=0.
- A write to a read-only responder register, or to an unmapped address, receives no `wr_valid`. It therefore completes with `rsp_err`=1.
- Timeout counter width: $clog2(TIMEOUT+1) bits. The counter never wraps because it is cleared on every accept.
- One outstanding request only; there is no response backpressure. The core must accept `rsp_valid` when it is pulsed.

## Timing

- Reset values:
  - state=IDLE, `req_ready`=1 (decoded from state).
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - All `bus_*` outputs 0, counter 0.
- Outputs: `req_ready`, `bus_rd` and `bus_wr` are decoded from state only; none depends combinationally on any input. The remaining outputs are registered.
- Latency, with the request accepted at edge ending cycle T:
  - Read, same-cycle ack: `bus_rd` high in T+1, `rsp_valid` in T+2.
  - Write, registered ack: `bus_wr` in T+1, ack seen in T+2, `rsp_valid` in T+3.
  - Timeout, read: `bus_rd` high for exactly TIMEOUT cycles (T+1..T+TIMEOUT), `rsp_valid` with err in T+TIMEOUT+1.
  - Timeout, write: `rsp_valid` with err in T+TIMEOUT+2.
- Next accept: earliest is the cycle after `rsp_valid`. Back-to-back reads therefore run at 3 cycles per transaction.
- Reset mid-operation: strobes drop immediately (asynchronous), the in-flight request is discarded with no `rsp_valid`, and the block is in IDLE on reset release.

## Test plan

- Read: stub responder returns 0xA5A5_0001 combinationally for 0x2000_0000. Accept at T → `bus_rd` exactly cycle T+1; `rsp_valid`=1, `rsp_rdata`=0xA5A5_0001, `rsp_err`=0 at T+2.
- Write: 0xDEAD_BEEF, mask 0xF, to 0x2000_0004, responder with registered ack → `bus_wr` high exactly 1 cycle (T+1); addr/data stable T+1..T+2; `rsp_valid`, err=0, rdata=0 at T+3.
- Unmapped read (no responder), TIMEOUT=16 → `bus_rd` high 16 cycles; `rsp_valid`, `rsp_err`=1, `rsp_rdata`=0 at T+17. Write to read-only address → err at T+18.
- Responder delayed to acknowledge on the 16th RD cycle, data 0x1234 → err=0, rdata=0x1234, `rsp_valid` at T+17.
- Spurious `bus_wr_valid` pulse during RD, followed by `bus_rd_valid` → response reflects the read only, err=0. `rst` asserted in WR_WAIT → `bus_*` all 0 immediately, no `rsp_valid`, `req_ready`=1.
- `req_valid` held high with three queued reads → exactly three `rsp_valid` pulses, spaced 3 cycles apart, data in request order.
